// File: rtl/pam5_tcm_tx_encoder_if.sv
// rtl/pam5_tcm_tx_encoder_if.sv - byte stream handshake into the PAM5 TCM transmit encoder
interface pam5_tcm_tx_encoder_if;
  logic       io_in_valid;
  logic [7:0] io_in_bits;
  logic       io_in_last;
  logic       io_in_ready;

  modport master (
    output io_in_valid,
    output io_in_bits,
    output io_in_last,
    input  io_in_ready
  );

  modport slave (
    input  io_in_valid,
    input  io_in_bits,
    input  io_in_last,
    output io_in_ready
  );
endinterface

// File: rtl/pam5_tcm_tx_encoder.sv
// rtl/pam5_tcm_tx_encoder.sv - 4D-PAM5 trellis-coded transmit symbol encoder with framing and scrambler
module pam5_tcm_tx_encoder #(
  parameter bit          SCRAMBLE_EN = 1'b1,
  parameter logic [32:0] SCR_SEED    = 33'h1_0000_0001,
  parameter int          IPG_MIN     = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  pam5_tcm_tx_encoder_if.slave        in_if,
  output logic [11:0]                 io_txSymbols,
  output logic [1:0]                  io_txCtrl,
  output logic                        io_txValid,
  output logic                        io_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SSD1,
    ST_SSD2,
    ST_DATA,
    ST_ESD1,
    ST_ESD2
  } state_t;

  localparam logic [11:0] SYM_IDLE = 12'h000;
  localparam logic [11:0] SYM_SSD1 = 12'h492;
  localparam logic [11:0] SYM_SSD2 = 12'h496;
  localparam logic [11:0] SYM_ESD1 = 12'hDB6;
  localparam logic [11:0] SYM_ESD2 = 12'hDB2;

  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_SSD  = 2'd1;
  localparam logic [1:0] CTRL_DATA = 2'd2;
  localparam logic [1:0] CTRL_ESD  = 2'd3;

  localparam logic [7:0] GAP_INIT = 8'(IPG_MIN);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cs;
  logic [2:0]  cs_nxt;
  logic [32:0] lfsr;
  logic [32:0] lfsr_step;
  logic [7:0]  gap;
  logic [7:0]  gap_nxt;
  logic [7:0]  scr_byte;
  logic [7:0]  scr_bits;
  logic [11:0] data_sym;
  logic [11:0] sym_nxt;
  logic [1:0]  ctrl_nxt;
  logic        err_nxt;

  // PAM5 3-bit code for a lane level chosen by two data bits, optionally sign-inverted.
  function automatic logic [2:0] lane_code(input logic [1:0] pair, input logic neg);
    logic [2:0] code;
    case ({neg, pair})
      3'b000:  code = 3'b111;
      3'b001:  code = 3'b001;
      3'b010:  code = 3'b110;
      3'b011:  code = 3'b010;
      3'b100:  code = 3'b001;
      3'b101:  code = 3'b111;
      3'b110:  code = 3'b010;
      default: code = 3'b110;
    endcase
    return code;
  endfunction

  assign in_if.io_in_ready = (state == ST_DATA);

  // Eight serial LFSR steps per clock; the feedback bit of step i is scrambler bit i.
  always_comb begin
    lfsr_step = lfsr;
    scr_byte  = '0;
    for (int i = 0; i < 8; i++) begin
      scr_byte[i] = lfsr_step[32] ^ lfsr_step[12];
      lfsr_step   = {lfsr_step[31:0], scr_byte[i]};
    end
  end

  always_comb begin
    scr_bits = SCRAMBLE_EN ? (in_if.io_in_bits ^ scr_byte) : in_if.io_in_bits;
    data_sym = '0;
    for (int k = 0; k < 4; k++) begin
      data_sym[3*k +: 3] = lane_code(scr_bits[2*k +: 2], cs[0]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sym_nxt   = SYM_IDLE;
    ctrl_nxt  = CTRL_IDLE;
    err_nxt   = 1'b0;
    cs_nxt    = cs;
    gap_nxt   = gap;
    case (state)
      ST_IDLE: begin
        if (gap != 8'd0) begin
          gap_nxt = gap - 8'd1;
        end else if (in_if.io_in_valid) begin
          state_nxt = ST_SSD1;
        end
      end
      ST_SSD1: begin
        sym_nxt   = SYM_SSD1;
        ctrl_nxt  = CTRL_SSD;
        cs_nxt    = 3'b000;
        state_nxt = ST_SSD2;
      end
      ST_SSD2: begin
        sym_nxt   = SYM_SSD2;
        ctrl_nxt  = CTRL_SSD;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (in_if.io_in_valid) begin
          sym_nxt  = data_sym;
          ctrl_nxt = CTRL_DATA;
          cs_nxt   = {cs[1], cs[0] ^ scr_bits[7], cs[2] ^ scr_bits[6]};
          if (in_if.io_in_last) begin
            state_nxt = ST_ESD1;
          end
        end else begin
          // Source underrun: the abort ESD1 replaces the missing byte and skips the ESD1 state.
          sym_nxt   = SYM_ESD1;
          ctrl_nxt  = CTRL_ESD;
          err_nxt   = 1'b1;
          state_nxt = ST_ESD2;
        end
      end
      ST_ESD1: begin
        sym_nxt   = SYM_ESD1;
        ctrl_nxt  = CTRL_ESD;
        state_nxt = ST_ESD2;
      end
      ST_ESD2: begin
        sym_nxt   = SYM_ESD2;
        ctrl_nxt  = CTRL_ESD;
        gap_nxt   = GAP_INIT;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cs           <= 3'b000;
      lfsr         <= SCR_SEED;
      gap          <= 8'd0;
      io_txSymbols <= SYM_IDLE;
      io_txCtrl    <= CTRL_IDLE;
      io_txValid   <= 1'b0;
      io_err       <= 1'b0;
    end else begin
      cs           <= cs_nxt;
      lfsr         <= lfsr_step;
      gap          <= gap_nxt;
      io_txSymbols <= sym_nxt;
      io_txCtrl    <= ctrl_nxt;
      io_txValid   <= 1'b1;
      io_err       <= err_nxt;
    end
  end

endmodule
